// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219 serial display transmitter.
// Frames are {4'h0, addr, data}; frames 0-4 configure the chip, 5-12 carry digits.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOOP       = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] ADDR_DECODE     = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] ADDR_TEST       = 4'hF;

    localparam int INIT_FRAMES  = 5;
    localparam int DIGIT_FRAMES = 8;

    localparam logic [3:0] LAST_INIT_FRAME   = 4'(INIT_FRAMES - 1);
    localparam logic [3:0] FIRST_DIGIT_FRAME = 4'(INIT_FRAMES);
    localparam logic [3:0] LAST_FRAME        = 4'(INIT_FRAMES + DIGIT_FRAMES - 1);

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_FRAME,
        SEQ_SHIFT
    } seq_state_e;

    typedef enum logic [2:0] {
        SH_IDLE,
        SH_SCLK_LO,
        SH_SCLK_HI,
        SH_LATCH,
        SH_GAP
    } sh_state_e;

    function automatic logic [15:0] make_frame(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/max7219_shift16.sv
// Serialises one 16-bit frame MSB first: SCLK_HALF-cycle low/high sclk phases,
// then a SCLK_HALF-cycle load pulse and an equal gap with all lines quiet.
module max7219_shift16
    import max7219_pkg::*;
#(
    parameter int SCLK_HALF = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_word,
    output logic        o_idle,
    output logic        o_dout,
    output logic        o_sclk,
    output logic        o_load
);

    localparam logic [7:0] PHASE_RELOAD = 8'(SCLK_HALF - 1);

    sh_state_e   state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] sr_q, sr_d;
    logic        sclk_q, sclk_d;
    logic        load_q, load_d;
    logic        phase_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= SH_IDLE;
            phase_q <= 8'd0;
            bit_q   <= 4'd0;
            sr_q    <= 16'd0;
            sclk_q  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            sclk_q  <= sclk_d;
            load_q  <= load_d;
        end
    end

    assign phase_done = (phase_q == 8'd0);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        sclk_d  = sclk_q;
        load_d  = load_q;
        case (state_q)
            SH_IDLE: begin
                if (i_start) begin
                    sr_d    = i_word;
                    sclk_d  = 1'b0;
                    load_d  = 1'b0;
                    bit_d   = 4'd15;
                    phase_d = PHASE_RELOAD;
                    state_d = SH_SCLK_LO;
                end
            end
            SH_SCLK_LO: begin
                if (phase_done) begin
                    sclk_d  = 1'b1;
                    phase_d = PHASE_RELOAD;
                    state_d = SH_SCLK_HI;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            SH_SCLK_HI: begin
                if (phase_done) begin
                    sclk_d  = 1'b0;
                    phase_d = PHASE_RELOAD;
                    if (bit_q == 4'd0) begin
                        load_d  = 1'b1;
                        state_d = SH_LATCH;
                    end else begin
                        // dout is sr_q[15], so the shift moves the next bit out on the falling sclk
                        bit_d   = bit_q - 4'd1;
                        sr_d    = {sr_q[14:0], 1'b0};
                        state_d = SH_SCLK_LO;
                    end
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            SH_LATCH: begin
                if (phase_done) begin
                    load_d  = 1'b0;
                    phase_d = PHASE_RELOAD;
                    state_d = SH_GAP;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            SH_GAP: begin
                if (phase_done) begin
                    phase_d = PHASE_RELOAD;
                    state_d = SH_IDLE;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            default: state_d = SH_IDLE;
        endcase
    end

    // Idle also during the final gap cycle so back-to-back frames add no dead cycle.
    assign o_idle = (state_q == SH_IDLE) || ((state_q == SH_GAP) && phase_done);
    assign o_dout = sr_q[15];
    assign o_sclk = sclk_q;
    assign o_load = load_q;

endmodule

// File: rtl/max7219_display_tx.sv
// MAX7219 transmitter: configuration frames after reset, then eight digit frames
// from a snapshot of i_digits whenever the pending flag is set.
module max7219_display_tx
    import max7219_pkg::*;
#(
    parameter int         SCLK_HALF = 1,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [63:0] i_digits,
    input  logic        i_update,
    output logic        o_serial_dout,
    output logic        o_serial_clk,
    output logic        o_serial_load,
    output logic        o_busy,
    output logic        o_done
);

    seq_state_e  state_q, state_d;
    logic        pend_q, pend_d;
    logic [3:0]  frame_q, frame_d;
    logic [63:0] snap_q, snap_d;
    logic        done_q, done_d;
    logic        sh_start;
    logic        sh_idle;
    logic [15:0] frame_word;
    logic [2:0]  digit_idx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= SEQ_IDLE;
            pend_q  <= 1'b1;
            frame_q <= 4'd0;
            snap_q  <= 64'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            frame_q <= frame_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
        end
    end

    // Frame index 12 wraps to digit index 7 in three bits.
    assign digit_idx = frame_q[2:0] - FIRST_DIGIT_FRAME[2:0];

    always_comb begin
        case (frame_q)
            4'd0:                frame_word = make_frame(ADDR_SHUTDOWN, 8'h01);
            4'd1:                frame_word = make_frame(ADDR_DECODE, 8'h00);
            4'd2:                frame_word = make_frame(ADDR_SCAN_LIMIT, 8'h07);
            4'd3:                frame_word = make_frame(ADDR_INTENSITY, {4'h0, INTENSITY});
            4'd4:                frame_word = make_frame(ADDR_TEST, 8'h00);
            4'd13, 4'd14, 4'd15: frame_word = make_frame(ADDR_NOOP, 8'h00);
            default:             frame_word = make_frame(ADDR_DIGIT0 + {1'b0, digit_idx},
                                                         snap_q[{digit_idx, 3'b000} +: 8]);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q | i_update;
        frame_d  = frame_q;
        snap_d   = snap_q;
        done_d   = 1'b0;
        sh_start = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (pend_q) begin
                    state_d = SEQ_FRAME;
                    // Frame 0 here means init; the flag is consumed when the refresh begins.
                    if (frame_q != 4'd0) begin
                        pend_d  = i_update;
                        snap_d  = i_digits;
                        frame_d = FIRST_DIGIT_FRAME;
                    end
                end
            end
            SEQ_FRAME: begin
                sh_start = 1'b1;
                state_d  = SEQ_SHIFT;
            end
            SEQ_SHIFT: begin
                if (sh_idle) begin
                    if ((frame_q == LAST_INIT_FRAME) && pend_q) begin
                        pend_d  = i_update;
                        snap_d  = i_digits;
                        frame_d = FIRST_DIGIT_FRAME;
                        state_d = SEQ_FRAME;
                    end else if ((frame_q == LAST_INIT_FRAME) || (frame_q == LAST_FRAME)) begin
                        frame_d = FIRST_DIGIT_FRAME;
                        done_d  = 1'b1;
                        state_d = SEQ_IDLE;
                    end else begin
                        frame_d = frame_q + 4'd1;
                        state_d = SEQ_FRAME;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    max7219_shift16 #(
        .SCLK_HALF(SCLK_HALF)
    ) u_shift (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_start(sh_start),
        .i_word (frame_word),
        .o_idle (sh_idle),
        .o_dout (o_serial_dout),
        .o_sclk (o_serial_clk),
        .o_load (o_serial_load)
    );

    assign o_busy = (state_q != SEQ_IDLE);
    assign o_done = done_q;

endmodule

// File: tb/tb_max7219_display_tx.sv
// Bench for max7219_display_tx: two instances (SCLK_HALF 1 and 3) decoded by a
// receiver monitor and compared against frames predicted from the register map.
module tb_max7219_display_tx;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  upd = 2'b00;
    logic [63:0] dig0 = 64'd0;
    logic [63:0] dig1 = 64'd0;
    logic [1:0]  dout_w, sclk_w, load_w, busy_w, done_w;

    always #5 clk = ~clk;

    max7219_display_tx #(.SCLK_HALF(1), .INTENSITY(4'h8)) dut0 (
        .i_clk(clk), .i_reset(rst[0]), .i_digits(dig0), .i_update(upd[0]),
        .o_serial_dout(dout_w[0]), .o_serial_clk(sclk_w[0]), .o_serial_load(load_w[0]),
        .o_busy(busy_w[0]), .o_done(done_w[0])
    );

    max7219_display_tx #(.SCLK_HALF(3), .INTENSITY(4'h3)) dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_digits(dig1), .i_update(upd[1]),
        .o_serial_dout(dout_w[1]), .o_serial_clk(sclk_w[1]), .o_serial_load(load_w[1]),
        .o_busy(busy_w[1]), .o_done(done_w[1])
    );

    logic [15:0] exp0_q[$];
    logic [15:0] exp1_q[$];
    int          dur0_q[$];
    int          dur1_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rise0 = 0;

    logic [15:0] rx_sh[2];
    int          rx_n[2], since_d[2], hi_run[2], lo_run[2], ld_run[2], busy_cnt[2];
    logic        p_sclk[2], p_load[2], p_busy[2], p_dout[2], p_rst[2];

    function automatic int half(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic int frame_len(input int u);
        return 1 + 34 * half(u);
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input int u, input logic [15:0] w);
        if (u == 0) exp0_q.push_back(w);
        else        exp1_q.push_back(w);
    endtask

    task automatic push_dur(input int u, input int d);
        if (u == 0) dur0_q.push_back(d);
        else        dur1_q.push_back(d);
    endtask

    // Reference model: eight digit writes, address k+1 gets byte k of the image.
    task automatic push_refresh(input int u, input logic [63:0] img);
        for (int k = 0; k < 8; k++) push_word(u, {4'h0, 4'(k + 1), img[8*k +: 8]});
        push_dur(u, 8 * frame_len(u));
    endtask

    task automatic push_init(input int u, input logic [63:0] img, input logic [3:0] inten);
        push_word(u, 16'h0C01);
        push_word(u, 16'h0900);
        push_word(u, 16'h0B07);
        push_word(u, {12'h0A0, inten});
        push_word(u, 16'h0F00);
        for (int k = 0; k < 8; k++) push_word(u, {4'h0, 4'(k + 1), img[8*k +: 8]});
        push_dur(u, 13 * frame_len(u));
    endtask

    task automatic pop_word(input int u, output bit ok, output logic [15:0] w);
        ok = 1'b0;
        w  = 16'd0;
        if (u == 0 && exp0_q.size() > 0) begin w = exp0_q.pop_front(); ok = 1'b1; end
        if (u == 1 && exp1_q.size() > 0) begin w = exp1_q.pop_front(); ok = 1'b1; end
    endtask

    task automatic pop_dur(input int u, output bit ok, output int d);
        ok = 1'b0;
        d  = 0;
        if (u == 0 && dur0_q.size() > 0) begin d = dur0_q.pop_front(); ok = 1'b1; end
        if (u == 1 && dur1_q.size() > 0) begin d = dur1_q.pop_front(); ok = 1'b1; end
    endtask

    // Receiver model and line-discipline checks, sampled on the falling clock.
    task automatic mon_unit(input int u);
        int          hh;
        bit          ok;
        logic [15:0] w;
        int          d;
        logic        s_rise, s_fall, l_rise, l_fall, b_fall;
        hh = half(u);
        if (rst[u]) begin
            if (p_rst[u])
                chk($sformatf("u%0d_reset_lines", u),
                    {dout_w[u], sclk_w[u], load_w[u], busy_w[u], done_w[u]}, 0);
            rx_n[u] = 0; rx_sh[u] = 16'd0; since_d[u] = 0;
            hi_run[u] = 0; lo_run[u] = 0; ld_run[u] = 0; busy_cnt[u] = 0;
            p_sclk[u] = 1'b0; p_load[u] = 1'b0; p_busy[u] = 1'b0; p_dout[u] = 1'b0;
            p_rst[u] = 1'b1;
            return;
        end
        p_rst[u] = 1'b0;
        s_rise = sclk_w[u] && !p_sclk[u];
        s_fall = !sclk_w[u] && p_sclk[u];
        l_rise = load_w[u] && !p_load[u];
        l_fall = !load_w[u] && p_load[u];
        b_fall = !busy_w[u] && p_busy[u];
        since_d[u] = (dout_w[u] != p_dout[u]) ? 1 : since_d[u] + 1;
        if (sclk_w[u] || load_w[u])
            chk($sformatf("u%0d_load_while_sclk", u), sclk_w[u] & load_w[u], 0);
        if (s_rise) begin
            chk($sformatf("u%0d_dout_setup", u), since_d[u] > hh, 1);
            if (rx_n[u] > 0) chk($sformatf("u%0d_sclk_low_width", u), lo_run[u], hh);
            rx_sh[u] = {rx_sh[u][14:0], dout_w[u]};
            rx_n[u]++;
            if (u == 0) rise0++;
            hi_run[u] = 0;
        end
        if (s_fall) begin
            chk($sformatf("u%0d_sclk_high_width", u), hi_run[u], hh);
            lo_run[u] = 0;
        end
        if (sclk_w[u]) hi_run[u]++;
        else           lo_run[u]++;
        if (l_rise) begin
            chk($sformatf("u%0d_frame_bits", u), rx_n[u], 16);
            pop_word(u, ok, w);
            chk($sformatf("u%0d_frame_expected", u), ok, 1);
            if (ok) chk($sformatf("u%0d_frame_word", u), rx_sh[u], w);
            rx_n[u] = 0;
            ld_run[u] = 0;
        end
        if (l_fall) chk($sformatf("u%0d_load_width", u), ld_run[u], hh);
        if (load_w[u]) ld_run[u]++;
        if (done_w[u]) chk($sformatf("u%0d_done_with_busy_fall", u), b_fall, 1);
        if (b_fall) begin
            chk($sformatf("u%0d_done_pulse", u), done_w[u], 1);
            pop_dur(u, ok, d);
            chk($sformatf("u%0d_busy_expected", u), ok, 1);
            if (ok) chk($sformatf("u%0d_busy_cycles", u), busy_cnt[u], d);
            busy_cnt[u] = 0;
        end
        if (busy_w[u]) busy_cnt[u]++;
        p_sclk[u] = sclk_w[u];
        p_load[u] = load_w[u];
        p_busy[u] = busy_w[u];
        p_dout[u] = dout_w[u];
    endtask

    task automatic pulse(input int u);
        @(posedge clk); #1;
        upd[u] = 1'b1;
        @(posedge clk); #1;
        upd[u] = 1'b0;
    endtask

    task automatic wait_drain(input int u, input int budget);
        int n;
        int left;
        n = 0;
        left = (u == 0) ? exp0_q.size() + dur0_q.size() : exp1_q.size() + dur1_q.size();
        while (left != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
            left = (u == 0) ? exp0_q.size() + dur0_q.size() : exp1_q.size() + dur1_q.size();
        end
        chk($sformatf("u%0d_drain_outstanding", u), left, 0);
    endtask

    task automatic run_stimulus();
        logic [63:0] img;
        int          n;
        int          lat;
        int          base;
        push_init(0, 64'd0, 4'h8);
        push_init(1, 64'd0, 4'h3);
        repeat (4) @(posedge clk);
        #1 rst = 2'b00;
        wait_drain(0, 600);

        dig0 = 64'h7E30_6D79_3333_5B5F;
        push_refresh(0, dig0);
        pulse(0);
        wait_drain(0, 400);

        for (int i = 0; i < 4; i++) begin
            img = {$urandom, $urandom};
            dig0 = img;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            push_refresh(0, img);
            pulse(0);
            wait_drain(0, 400);
        end

        // Three requests during a refresh collapse into one refresh of the newest image.
        img = {$urandom, $urandom};
        dig0 = img;
        push_refresh(0, img);
        pulse(0);
        repeat (10) @(posedge clk);
        #1;
        img = {$urandom, $urandom};
        dig0 = img;
        push_refresh(0, img);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(2, 20)) @(posedge clk);
            pulse(0);
        end
        wait_drain(0, 800);

        // Request raised in the o_done cycle.
        img = {$urandom, $urandom};
        dig0 = img;
        push_refresh(0, img);
        pulse(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_w[0] && n < 400);
        chk("u0_done_seen", done_w[0], 1);
        img = {$urandom, $urandom};
        dig0 = img;
        upd[0] = 1'b1;
        push_refresh(0, img);
        lat = 0;
        do begin
            @(negedge clk);
            upd[0] = 1'b0;
            lat++;
        end while (!busy_w[0] && lat < 10);
        chk("u0_update_on_done_latency", lat, 2);
        wait_drain(0, 400);

        // Reset during bit 9 of the second digit frame.
        img = {$urandom, $urandom};
        dig0 = img;
        push_word(0, {4'h0, 4'h1, img[7:0]});
        base = rise0;
        pulse(0);
        n = 0;
        while ((rise0 - base) < 22 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("u0_reached_bit9", rise0 - base, 22);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        chk("u0_first_frame_latched", exp0_q.size(), 0);
        exp0_q.delete();
        dur0_q.delete();
        push_init(0, img, 4'h8);
        repeat (2) @(posedge clk);
        #1 rst[0] = 1'b0;
        wait_drain(0, 600);

        wait_drain(1, 100);
        img = {$urandom, $urandom};
        dig1 = img;
        push_refresh(1, img);
        pulse(1);
        wait_drain(1, 1000);
        repeat (5) @(posedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_unit(0);
                mon_unit(1);
            end
            run_stimulus();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/max7219_display_tx.md
# max7219_display_tx

Transmitter for the MAX7219 three-wire serial display interface used by the clock design's LED output. It drives the `serial_dout` / `serial_clk` / `serial_load` pins (`uio_out[1]`, `[3]`, `[0]`). After reset it sends the chip's configuration sequence, then writes all eight digit registers from a parallel 64-bit digit image whenever an update is requested. It is the transmitting end of the interface that the bench's MAX7219 receiver model decodes.

## Interface

Parameters:
- `SCLK_HALF`, default 1: `i_clk` cycles per serial-clock phase, legal range 1–255.
- `INTENSITY`, default 4'h8: value written to the intensity register during init.

Ports:
- `i_clk`  in  1  system clock (~10 MHz).
- `i_reset`  in  1  synchronous, active-high reset.
- `i_digits`  in  64  digit image; `i_digits[8k+7:8k]` goes to digit register address k+1 (bit 7 = DP, bits 6:0 = segments).
- `i_update`  in  1  single-cycle request to refresh all eight digits.
- `o_serial_dout`  out  1  serial data, MSB first.
- `o_serial_clk`  out  1  serial clock; the receiver samples on the rising edge.
- `o_serial_load`  out  1  latch strobe; the receiver latches on the rising edge.
- `o_busy`  out  1  high while any frame is in flight.
- `o_done`  out  1  one-cycle pulse when a sequence completes.

## Operation

Frame format:
- Each frame is 16 bits: `{4'h0, addr[3:0], data[7:0]}`, sent bit 15 first.

Init sequence (frames 0–4):
- `0x0C01` shutdown off.
- `0x0900` no decode.
- `0x0B07` scan limit 7.
- `0x0A0<INTENSITY>` intensity.
- `0x0F00` display test off.

Digit refresh (frames 5–12):
- Addresses 1..8, data taken from a snapshot of `i_digits`.
- The snapshot is captured when the refresh starts, not per frame.

Pending flag:
- Reset sets it, so 13 frames go out after reset.
- `i_update` sets it in any state, including during init. Multiple requests while busy collapse into one.
- In IDLE with the flag set: clear the flag, snapshot `i_digits`, start a refresh.

FSM states:
- IDLE → FRAME when the flag is set.
- FRAME loads the shift register, sets dout = bit 15, sclk = 0 → SCLK_LO.
- SCLK_LO (SCLK_HALF cycles) → SCLK_HI (sclk = 1, SCLK_HALF cycles).
- SCLK_HI → SCLK_LO with the next bit after bits 15..1.
- SCLK_HI → LATCH after bit 0.
- LATCH: sclk = 0, load = 1 for SCLK_HALF cycles → GAP.
- GAP: load = 0 for SCLK_HALF cycles → FRAME for the next frame, or IDLE after the last frame (frame 4 ends init; frame 12 ends a refresh).
- Leaving to IDLE raises `o_done` for one cycle. If the flag is already set, the next refresh starts on the following cycle.
- After init, if the flag is clear (impossible after reset, but defined): go to IDLE and pulse `o_done`.

Bit and phase counters:
- Bit counter: 4 bits, counting 15→0.
- Phase counter: 8 bits, reloaded to SCLK_HALF-1 at every state change.

## Timing

Reset values:
- All outputs 0.
- Flag = 1, FSM = IDLE, frame index = 0.

Start of a sequence:
- With the flag set in IDLE at edge N, edge N+1 enters FRAME.
- At edge N+2: busy = 1, dout = bit 15, sclk = 0.

Line discipline:
- dout changes only on a cycle where sclk transitions 1→0 or on frame start, so it is stable for SCLK_HALF cycles before each rising sclk.
- load is never high while sclk is high.

Frame length:
- 1 (FRAME) + 32·SCLK_HALF + 2·SCLK_HALF cycles.
- SCLK_HALF = 1 gives 35 cycles per frame.
- Post-reset 13-frame sequence = 455 cycles; an 8-frame refresh = 280 cycles.

Completion:
- `o_busy` falls on the same edge where `o_done` pulses.

Reset mid-frame:
- Lines go low immediately and the full init sequence restarts.
- The partial frame is simply never latched, because load stays low.

Simultaneous events:
- `i_update` on the same cycle as `o_done` is kept, and its refresh follows.

## Structure

Package `max7219_pkg`:
- Register address constants: NOOP 0x0, DIGIT0 0x1, DECODE 0x9, INTENSITY 0xA, SCAN_LIMIT 0xB, SHUTDOWN 0xC, TEST 0xF.
- FSM state typedef.
- Init frame count (5) and digit frame count (8).

Sub-module `max7219_shift16`:
- Loads a 16-bit word and produces dout, sclk and load with SCLK_HALF timing.
- Handshake: `i_start`, `o_idle`.
- The top level owns frame sequencing, the snapshot and the pending flag.

## Test plan

- **Init after reset.** Release reset, leave `i_update` low. The bench receiver decodes 13 frames: `0C01`, `0900`, `0B07`, `0A08`, `0F00`, then addresses 1–8 with data 00. `o_done` pulses once, 455 cycles after reset release.
- **Refresh.** Set `i_digits` = 64'h7E30_6D79_3333_5B5F (bytes high to low, so address 1 gets the low byte) and pulse `i_update` in IDLE. Receiver digit7..digit0 = 7E,30,6D,79,33,33,5B,5F. busy lasts 280 cycles.
- **Coalescing.** Pulse `i_update` three times during a refresh and change `i_digits` before the first pulse is serviced. Exactly one more refresh follows, carrying the latest image.
- **Reset mid-frame.** Assert reset at bit 9 of a digit frame. All lines go low next cycle, no load edge occurs for that frame, and a full init restarts.
- **SCLK_HALF = 3.** Each sclk high/low phase is 3 cycles, load high is 3 cycles, dout is stable ≥3 cycles before every rising sclk, and a frame is 103 cycles.
- **Boundary.** `i_update` on the same cycle as `o_done` starts the next refresh 2 cycles later, with no lost request.
